// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction-fetch stage. Owns the fetch PC, drives the
//            instruction SRAM read port and hands {ce, pc} to decode.
//            Redirects that arrive while the stage is stalled are latched
//            and applied on release. The latest redirect wins, and a live
//            redirect on the release cycle takes priority.
// Options  : IF_ADDR_CHECK_EN - flag misaligned fetch addresses (adel),
//            suppress the SRAM enable for them and carry adel as bit 33
//            of if_to_id_bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
`ifdef IF_ADDR_CHECK_EN
    output logic [33:0] if_to_id_bus,
`else
    output logic [32:0] if_to_id_bus,
`endif
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata
);

    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_RUN     = 2'd1,
        S_HOLD    = 2'd2,
        S_BR_PEND = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        ce_q;
    logic [31:0] pend_addr_q;

    logic        br_e;
    logic [31:0] br_addr;
    logic        if_hold;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;
    logic [4:0]  stall_unused;

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];
    assign if_hold = stall[0];
    // Only the IF hold bit matters to this stage; the rest belong downstream.
    assign stall_unused = stall[5:1];

    // Sequential successor wraps silently at the top of the address space.
    assign seq_pc  = pc_q + 32'd4;
    // Unstalled successor: a live redirect beats the sequential path.
    assign next_pc = br_e ? br_addr : seq_pc;

    // Fetch PC, fetch enable, pending redirect and control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            ce_q        <= 1'b0;
            pend_addr_q <= 32'd0;
            state_q     <= S_BOOT;
        end else begin
            case (state_q)
                S_BOOT: begin
                    if (!if_hold) begin
                        pc_q    <= next_pc;
                        ce_q    <= 1'b1;
                        state_q <= S_RUN;
                    end else if (br_e) begin
                        // Keep a redirect seen before the first fetch.
                        pend_addr_q <= br_addr;
                        state_q     <= S_BR_PEND;
                    end
                end
                S_RUN, S_HOLD: begin
                    if (!if_hold) begin
                        pc_q    <= next_pc;
                        ce_q    <= 1'b1;
                        state_q <= S_RUN;
                    end else if (br_e) begin
                        pend_addr_q <= br_addr;
                        state_q     <= S_BR_PEND;
                    end else begin
                        state_q <= S_HOLD;
                    end
                end
                S_BR_PEND: begin
                    if (!if_hold) begin
                        pc_q    <= br_e ? br_addr : pend_addr_q;
                        ce_q    <= 1'b1;
                        state_q <= S_RUN;
                    end else if (br_e) begin
                        // Newer redirect replaces the older one.
                        pend_addr_q <= br_addr;
                    end
                end
                default: state_q <= S_BOOT;
            endcase
        end
    end

    assign inst_sram_addr  = pc_q;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'd0;

`ifdef IF_ADDR_CHECK_EN
    logic adel;
    assign adel          = (pc_q[1:0] != 2'b00) & ce_q;
    assign inst_sram_en  = ce_q & ~adel;
    assign if_to_id_bus  = {adel, ce_q, pc_q};
`else
    assign inst_sram_en  = ce_q;
    assign if_to_id_bus  = {ce_q, pc_q};
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Self-checking bench for if_stage. A transaction-level model
//            (current pc, enable, optional pending redirect) predicts the
//            outputs after every clock; directed sequences add fixed
//            expected addresses, then randomized traffic runs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;
`ifdef IF_ADDR_CHECK_EN
    localparam int BW = 34;
`else
    localparam int BW = 33;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic [32:0]   br_bus;
    logic [BW-1:0] if_to_id_bus;
    logic          inst_sram_en;
    logic [3:0]    inst_sram_wen;
    logic [31:0]   inst_sram_addr;
    logic [31:0]   inst_sram_wdata;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_pend_v;
    logic [31:0] m_pend;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behaviour per clock: reset wins; a stalled cycle only remembers the
    // newest redirect; an unstalled cycle moves to the live redirect, else
    // the remembered one, else pc+4, and enables fetch.
    task automatic model_clock(input logic r, input logic hold, input logic be, input logic [31:0] ba);
        if (r) begin
            m_pc     = RESET_PC;
            m_ce     = 1'b0;
            m_pend_v = 1'b0;
            m_pend   = 32'd0;
        end else if (hold) begin
            if (be) begin
                m_pend_v = 1'b1;
                m_pend   = ba;
            end
        end else begin
            if (be)            m_pc = ba;
            else if (m_pend_v) m_pc = m_pend;
            else               m_pc = m_pc + 32'd4;
            m_ce     = 1'b1;
            m_pend_v = 1'b0;
        end
    endtask

    task automatic compare_model(input string tag);
        logic          exp_en;
        logic [BW-1:0] exp_bus;
`ifdef IF_ADDR_CHECK_EN
        logic adel;
        adel    = (m_pc[1:0] != 2'b00) && m_ce;
        exp_en  = m_ce && !adel;
        exp_bus = {adel, m_ce, m_pc};
`else
        exp_en  = m_ce;
        exp_bus = {m_ce, m_pc};
`endif
        check({tag, ".addr"}, 64'(inst_sram_addr), 64'(m_pc));
        check({tag, ".en"},   64'(inst_sram_en),   64'(exp_en));
        check({tag, ".bus"},  64'(if_to_id_bus),   64'(exp_bus));
        check({tag, ".wen"},  64'(inst_sram_wen),  64'd0);
        check({tag, ".wd"},   64'(inst_sram_wdata), 64'd0);
    endtask

    // Apply one cycle of inputs, clock it, then compare #1 after the edge.
    task automatic step(input string tag, input logic r, input logic [5:0] st,
                        input logic be, input logic [31:0] ba);
        rst    = r;
        stall  = st;
        br_bus = {be, ba};
        @(posedge clk);
        model_clock(r, st[0], be, ba);
        #1;
        compare_model(tag);
    endtask

    initial begin
        rst    = 1'b1;
        stall  = 6'd0;
        br_bus = 33'd0;
        m_pc = RESET_PC; m_ce = 1'b0; m_pend_v = 1'b0; m_pend = 32'd0;
        #1;

        // Boot sequence.
        step("rst", 1'b1, 6'd0, 1'b0, 32'd0);
        check("rst_addr", 64'(inst_sram_addr), 64'hBFBF_FFFC);
        check("rst_en",   64'(inst_sram_en), 64'd0);
        step("boot0", 1'b0, 6'd0, 1'b0, 32'd0);
        check("boot0_addr", 64'(inst_sram_addr), 64'hBFC0_0000);
        check("boot0_en",   64'(inst_sram_en), 64'd1);
        step("boot1", 1'b0, 6'd0, 1'b0, 32'd0);
        check("boot1_addr", 64'(inst_sram_addr), 64'hBFC0_0004);

        // Unstalled redirect: one-cycle latency.
        step("redir", 1'b0, 6'd0, 1'b1, 32'h0000_1000);
        check("redir_addr", 64'(inst_sram_addr), 64'h0000_1000);
        step("redir1", 1'b0, 6'd0, 1'b0, 32'hDEAD_BEEF);
        check("redir1_addr", 64'(inst_sram_addr), 64'h0000_1004);

        // Redirect in the first stalled cycle, held for three cycles.
        step("stb0", 1'b0, 6'b000011, 1'b1, 32'h0000_2000);
        check("stb0_addr", 64'(inst_sram_addr), 64'h0000_1004);
        step("stb1", 1'b0, 6'd1, 1'b0, 32'h1111_1110);
        step("stb2", 1'b0, 6'd1, 1'b0, 32'd0);
        check("stb2_addr", 64'(inst_sram_addr), 64'h0000_1004);
        step("stb3", 1'b0, 6'd0, 1'b0, 32'd0);
        check("stb3_addr", 64'(inst_sram_addr), 64'h0000_2000);
        step("stb4", 1'b0, 6'd0, 1'b0, 32'd0);
        check("stb4_addr", 64'(inst_sram_addr), 64'h0000_2004);

        // Latest pending redirect wins.
        step("lw0", 1'b0, 6'd1, 1'b1, 32'h0000_3000);
        step("lw1", 1'b0, 6'd1, 1'b1, 32'h0000_4000);
        step("lw2", 1'b0, 6'd0, 1'b0, 32'd0);
        check("lw_addr", 64'(inst_sram_addr), 64'h0000_4000);
        // Live redirect on release beats the pending one.
        step("lv0", 1'b0, 6'd1, 1'b1, 32'h0000_6000);
        step("lv1", 1'b0, 6'd0, 1'b1, 32'h0000_5000);
        check("lv_addr", 64'(inst_sram_addr), 64'h0000_5000);

        // Wrap at the top of the address space.
        step("wr0", 1'b0, 6'd0, 1'b1, 32'hFFFF_FFFC);
        step("wr1", 1'b0, 6'd0, 1'b0, 32'd0);
        check("wrap_addr", 64'(inst_sram_addr), 64'h0000_0000);

        // Reset while a redirect is pending discards it.
        step("rp0", 1'b0, 6'd1, 1'b1, 32'h0000_7000);
        step("rp1", 1'b1, 6'd1, 1'b1, 32'h0000_8000);
        check("rp_addr", 64'(inst_sram_addr), 64'hBFBF_FFFC);
        check("rp_en",   64'(inst_sram_en), 64'd0);
        step("rp2", 1'b0, 6'd0, 1'b0, 32'd0);
        check("rp2_addr", 64'(inst_sram_addr), 64'hBFC0_0000);

        // Misaligned redirect target.
        step("mis", 1'b0, 6'd0, 1'b1, 32'h0000_1002);
        check("mis_low", 64'(if_to_id_bus[31:0]), 64'h0000_1002);
`ifdef IF_ADDR_CHECK_EN
        check("mis_en",   64'(inst_sram_en), 64'd0);
        check("mis_adel", 64'(if_to_id_bus[33]), 64'd1);
`else
        check("mis_en",   64'(inst_sram_en), 64'd1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic [5:0]  st;
            logic        be;
            logic [31:0] ba;
            r  = ($urandom_range(0, 99) < 2);
            st = 6'($urandom);
            st[0] = ($urandom_range(0, 99) < 40);
            be = ($urandom_range(0, 99) < 30);
            ba = $urandom;
            if ($urandom_range(0, 3) != 0) ba[1:0] = 2'b00;
            if ($urandom_range(0, 19) == 0) ba = 32'hFFFF_FFF8;
            step("rnd", r, st, be, ba);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide port clk, input, 1, rising-edge clock.
REQ-002 SHALL provide port rst, input, 1: synchronous, active-high reset; clock clk.
REQ-003 SHALL provide port stall, input, 6: pipeline stall vector; bit 0 = IF hold, 1 = Stop.
REQ-004 SHALL provide port br_bus, input, 33: {br_e[32], br_addr[31:0]} redirect from decode.
REQ-005 SHALL provide port if_to_id_bus, output, 33 (34 with IF_ADDR_CHECK_EN): {ce, pc}, with adel prepended as MSB when the macro is defined.
REQ-006 SHALL provide port inst_sram_en, output, 1: fetch enable.
REQ-007 SHALL provide port inst_sram_wen, output, 4: always 4'b0.
REQ-008 SHALL provide port inst_sram_addr, output, 32: fetch address.
REQ-009 SHALL provide port inst_sram_wdata, output, 32: always 32'b0.
REQ-010 SHALL provide parameter RESET_PC, default 32'hBFBF_FFFC: value pc_reg takes in reset, so the first fetch is at 32'hBFC0_0000.

Function
REQ-011 SHALL hold registers pc_reg[31:0], ce_reg, pend_addr[31:0], and state in {BOOT, RUN, HOLD, BR_PEND}.
REQ-012 SHALL drive inst_sram_addr = pc_reg, inst_sram_en = ce_reg, and if_to_id_bus = {ce_reg, pc_reg} combinationally from the registers.
REQ-013 SHALL compute seq_pc = pc_reg + 4, modulo 2^32, with wrap from 32'hFFFF_FFFC to 0 and no flag.
REQ-014 BOOT: on the first cycle after reset, SHALL set ce_reg = 1 and pc_reg = next_pc, then go to RUN; stall[0] in BOOT delays the exit.
REQ-015 RUN with stall[0] = 0: SHALL load pc_reg <= (br_e ? br_addr : seq_pc) and keep ce_reg = 1.
REQ-016 RUN with stall[0] = 1 and br_e = 0: SHALL hold pc_reg and ce_reg, then go to HOLD.
REQ-017 RUN with stall[0] = 1 and br_e = 1: SHALL latch pend_addr <= br_addr, hold pc_reg, then go to BR_PEND.
REQ-018 HOLD with stall[0] = 1: SHALL stay in HOLD, or on br_e go to BR_PEND and latch pend_addr.
REQ-019 HOLD with stall[0] = 0: SHALL behave as RUN for that cycle (REQ-015), then go to RUN.
REQ-020 BR_PEND with stall[0] = 1: SHALL stay in BR_PEND; a new br_e overwrites pend_addr (latest wins).
REQ-021 BR_PEND with stall[0] = 0: SHALL set pc_reg <= (br_e ? br_addr : pend_addr), with a live br_e taking priority, then go to RUN.
REQ-022 SHALL never drop a redirect: every br_e sampled during a stall appears as pc_reg after the stall ends.
REQ-023 Latency: a redirect presented in an unstalled cycle SHALL appear on inst_sram_addr on the next cycle.
REQ-024 SHALL ignore br_addr when br_e = 0.

Reset
REQ-025 rst SHALL set pc_reg = RESET_PC, ce_reg = 0, pend_addr = 0, state = BOOT; outputs are inst_sram_en = 0, if_to_id_bus = {0, RESET_PC} (plus adel = 0 with the macro).
REQ-026 rst SHALL override stall and br_e in the same cycle; reset asserted mid-stall or in BR_PEND discards pend_addr.

Configuration
REQ-027 Macro IF_ADDR_CHECK_EN: when defined, SHALL set adel = (pc_reg[1:0] != 0) & ce_reg.
REQ-028 With the macro defined: SHALL force inst_sram_en = 0 while adel = 1, and carry adel as if_to_id_bus[33].
REQ-029 With the macro defined: SHALL keep advancing pc_reg normally.
REQ-030 Macro undefined: SHALL build no check logic, fix the bus at 33 bits, and fetch regardless of alignment.

Verification
REQ-031 Boot: release rst, no stall -> inst_sram_addr = BFC00000, BFC00004, BFC00008 on consecutive cycles; en = 0 only in the reset cycle.
REQ-032 Redirect: br_bus = {1, 32'h0000_1000} while pc = BFC00004 -> next inst_sram_addr = 00001000, then 00001004.
REQ-033 Branch during stall: stall[0] = 1 for 3 cycles, br_e = 1 with 0x2000 in the first cycle only -> addr frozen for 3 cycles, then 0x2000, 0x2004.
REQ-034 Latest wins: within one stall, br_e with 0x3000 then 0x4000 -> after release addr = 0x4000; live br_e 0x5000 on the release cycle -> 0x5000.
REQ-035 Wrap and reset: pc = FFFFFFFC, no stall -> next addr = 00000000; rst asserted in BR_PEND -> addr = BFBFFFFC, en = 0, no pending redirect taken.
REQ-036 IF_ADDR_CHECK_EN: redirect to 0x1002 -> adel = 1, en = 0, bus[31:0] = 00001002; without the macro -> en = 1, bus is 33 bits.
